multicycle_control_unit: RTL

- Next-generation RV32I control unit. Replaces the single-cycle opcode decoder with a multicycle FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP).
- Adds ready/req handshakes to instruction and data memory, memory-wait timeout, illegal-opcode trap, optional JAL/JALR/LUI/AUIPC support, and a retired-instruction counter.
- Sits between the instruction register, datapath muxes, ALU control and memories.

---
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: run/opcode/memory handshakes in, datapath strobes out.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [6:0]       opcode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             alu_src;
  logic [1:0]       aluop;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic [1:0]       wb_sel;
  logic             reg_write;
  logic             branch;
  logic [1:0]       pc_src;
  logic             pc_write;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  run, opcode, imem_ready, dmem_ready,
    output imem_req, ir_write, alu_src, aluop,
    output mem_read, mem_write, mem_to_reg, wb_sel,
    output reg_write, branch, pc_src, pc_write,
    output trap, trap_cause, instret
  );

  modport slave (
    output run, opcode, imem_ready, dmem_ready,
    input  imem_req, ir_write, alu_src, aluop,
    input  mem_read, mem_write, mem_to_reg, wb_sel,
    input  reg_write, branch, pc_src, pc_write,
    input  trap, trap_cause, instret
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Ports: clk, rst_n (async low), bus (master side of control bus).
module multicycle_control_unit #(
  parameter bit ENABLE_JUMP  = 1'b1,
  parameter bit ENABLE_UPPER = 1'b1,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_unit_if.master bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  // Last wait cycle index; a miss here traps.
  localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_TRAP
  } state_t;

  state_t           state, nxt;
  logic [6:0]       op_q, op_d;
  logic [7:0]       wcnt, wcnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic             pc_wr;
  logic             legal;
  logic             c_r, c_i, c_ld, c_st;
  logic             c_br, c_j, c_lui, c_aui;

  always_comb begin
    legal = (bus.opcode == OP_R)  || (bus.opcode == OP_I)
         || (bus.opcode == OP_LD) || (bus.opcode == OP_ST)
         || (bus.opcode == OP_BR)
         || (ENABLE_JUMP && ((bus.opcode == OP_JAL)
                          || (bus.opcode == OP_JALR)))
         || (ENABLE_UPPER && ((bus.opcode == OP_LUI)
                           || (bus.opcode == OP_AUIPC)));
  end

  assign c_r   = (op_q == OP_R);
  assign c_i   = (op_q == OP_I);
  assign c_ld  = (op_q == OP_LD);
  assign c_st  = (op_q == OP_ST);
  assign c_br  = (op_q == OP_BR);
  assign c_j   = (op_q == OP_JAL) || (op_q == OP_JALR);
  assign c_lui = (op_q == OP_LUI);
  assign c_aui = (op_q == OP_AUIPC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wcnt      <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state   <= nxt;
      op_q    <= op_d;
      wcnt    <= wcnt_d;
      cause_q <= cause_d;
      if (pc_wr) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    nxt            = state;
    op_d           = op_q;
    wcnt_d         = wcnt;
    cause_d        = cause_q;
    pc_wr          = 1'b0;
    bus.imem_req   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.alu_src    = 1'b0;
    bus.aluop      = 2'b00;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.wb_sel     = 2'b00;
    bus.reg_write  = 1'b0;
    bus.branch     = 1'b0;
    bus.pc_src     = 2'b00;
    bus.trap       = 1'b0;
    bus.trap_cause = 2'b00;
    unique case (state)
      S_IDLE: if (bus.run) nxt = S_FETCH;
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          nxt = S_DECODE;
        end else if (wcnt == WAIT_MAX) begin
          nxt = S_TRAP;
          cause_d = 2'b11;
        end else begin
          wcnt_d = wcnt + 8'd1;
        end
      end
      S_DECODE: begin
        op_d = bus.opcode;
        if (legal) begin
          nxt = S_EXEC;
        end else begin
          nxt = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          c_r: begin
            bus.aluop = 2'b10;
            nxt = S_WB;
          end
          c_i: begin
            bus.aluop = 2'b11;
            bus.alu_src = 1'b1;
            nxt = S_WB;
          end
          c_ld, c_st: begin
            bus.alu_src = 1'b1;
            nxt = S_MEM;
          end
          c_br: begin
            bus.aluop  = 2'b01;
            bus.branch = 1'b1;
            bus.pc_src = 2'b01;
            pc_wr = 1'b1;
            nxt = S_FETCH;
          end
          c_j, c_aui: begin
            bus.alu_src = 1'b1;
            nxt = S_WB;
          end
          c_lui: nxt = S_WB;
          default: begin
            nxt = S_TRAP;
            cause_d = 2'b01;
          end
        endcase
      end
      S_MEM: begin
        bus.mem_read  = c_ld;
        bus.mem_write = c_st;
        // Ready on the final wait cycle still completes.
        if (bus.dmem_ready) begin
          if (c_ld) begin
            nxt = S_WB;
          end else begin
            pc_wr = 1'b1;
            nxt = S_FETCH;
          end
        end else if (wcnt == WAIT_MAX) begin
          nxt = S_TRAP;
          cause_d = 2'b10;
        end else begin
          wcnt_d = wcnt + 8'd1;
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        pc_wr = 1'b1;
        unique case (1'b1)
          c_ld: begin
            bus.wb_sel = 2'b01;
            bus.mem_to_reg = 1'b1;
          end
          c_j: begin
            bus.wb_sel = 2'b10;
            bus.pc_src = 2'b10;
          end
          c_lui: bus.wb_sel = 2'b11;
          default: bus.wb_sel = 2'b00;
        endcase
        nxt = S_FETCH;
      end
      S_TRAP: begin
        bus.trap = 1'b1;
        bus.trap_cause = cause_q;
      end
      default: nxt = S_IDLE;
    endcase
    if (nxt != state) wcnt_d = '0;
  end

  assign bus.pc_write = pc_wr;
  assign bus.instret  = instret_q;
endmodule
